// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: 16-way round-robin arbiter with registered one-hot grant.
// Optional owner hold limit (MAX_HOLD cycles) enabled by defining RR_ARB_HOLD_LIMIT_EN.
module round_robin_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  logic [0:0]  r_state;
  logic [3:0]  r_ptr;
  logic [3:0]  r_idx;
  logic [15:0] r_gnt;
  logic [15:0] w_cand;
  logic [3:0]  w_pick;
  logic        w_keep;
  logic        w_limit;
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..255");
  end
  // The current owner is never a candidate, so a preempted owner cannot re-win.
  assign w_cand = (r_state == GRANT) ? req & ~r_gnt : req;
  always_comb begin
    w_pick = '0;
    for (int k = 16; k >= 1; k--)
      if (w_cand[r_ptr + 4'(k)]) w_pick = r_ptr + 4'(k);
  end
`ifdef RR_ARB_HOLD_LIMIT_EN
  logic [7:0] r_cnt;
  logic       w_at_max;
  assign w_at_max = r_cnt == 8'(MAX_HOLD - 1);
  assign w_limit  = w_at_max && |w_cand;
  always_ff @(posedge clk)
    if (rst || !w_keep) r_cnt <= '0;
    else                r_cnt <= w_at_max ? r_cnt : r_cnt + 8'd1;
`else
  assign w_limit = 1'b0;
`endif
  assign w_keep = (r_state == GRANT) && req[r_idx] && !w_limit;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 4'd15;
      r_idx   <= '0;
      r_gnt   <= '0;
    end else if (!w_keep) begin
      r_state <= (|w_cand) ? GRANT : IDLE;
      r_ptr   <= (|w_cand) ? w_pick : r_ptr;
      r_idx   <= (|w_cand) ? w_pick : 4'd0;
      r_gnt   <= (|w_cand) ? 16'd1 << w_pick : 16'd0;
    end
  end
  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_state == GRANT;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: directed vectors; expected outputs queued per cycle, checked by a monitor.
module tb_round_robin_arbiter;
  typedef struct packed {
    logic [15:0] g;
    logic [3:0]  i;
    logic        v;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  round_robin_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );
  always #5 clk = ~clk;
  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic [15:0] rq, input int idx, input logic v);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    e.v = v;
    e.i = v ? 4'(idx) : 4'd0;
    e.g = v ? 16'd1 << idx : 16'd0;
    q.push_back(e);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_chk++;
        if (gnt !== e.g || gnt_idx !== e.i || gnt_valid !== e.v) begin
          n_fail++;
          $display("FAIL cycle_out t=%0t: got gnt=%h idx=%0d valid=%b, want gnt=%h idx=%0d valid=%b",
                   $time, gnt, gnt_idx, gnt_valid, e.g, e.i, e.v);
        end
        n_chk++;
        if (gnt !== (gnt_valid ? 16'd1 << gnt_idx : 16'd0)) begin
          n_fail++;
          $display("FAIL consistency t=%0t: gnt=%h idx=%0d valid=%b", $time, gnt, gnt_idx, gnt_valid);
        end
      end
    end
  end
  initial begin
    // reset with all requests asserted, then first grant from ptr=15
    step(1'b1, 16'hFFFF, 0, 1'b0);
    step(1'b1, 16'hFFFF, 0, 1'b0);
    step(1'b0, 16'hFFFF, 0, 1'b1);
    // rotation: each owner holds 2 cycles then drops its bit for one cycle
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 16'hFFFF, k, 1'b1);
      step(1'b0, 16'hFFFF & ~(16'd1 << k), (k + 1) % 16, 1'b1);
    end
    step(1'b0, 16'h0000, 0, 1'b0);
    // single requester
    for (int k = 0; k < 5; k++) step(1'b0, 16'h0100, 8, 1'b1);
    step(1'b0, 16'h0000, 0, 1'b0);
    // wrap from ptr=14
    step(1'b0, 16'h4000, 14, 1'b1);
    step(1'b0, 16'h0000, 0, 1'b0);
    step(1'b0, 16'h0009, 0, 1'b1);
    step(1'b0, 16'h0008, 3, 1'b1);
    step(1'b0, 16'h0000, 0, 1'b0);
    // mid-operation reset
    step(1'b0, 16'h0080, 7, 1'b1);
    step(1'b1, 16'h0081, 0, 1'b0);
    step(1'b0, 16'h0081, 0, 1'b1);
    step(1'b0, 16'h0080, 7, 1'b1);
    step(1'b0, 16'h0000, 0, 1'b0);
    // hold limit: req[2] held, req[5] raised at grant cycle 1
    step(1'b0, 16'h0004, 2, 1'b1);
    step(1'b0, 16'h0024, 2, 1'b1);
    step(1'b0, 16'h0024, 2, 1'b1);
    step(1'b0, 16'h0024, 2, 1'b1);
`ifdef RR_ARB_HOLD_LIMIT_EN
    step(1'b0, 16'h0024, 5, 1'b1);
    step(1'b0, 16'h0024, 5, 1'b1);
`else
    step(1'b0, 16'h0024, 2, 1'b1);
    step(1'b0, 16'h0024, 2, 1'b1);
`endif
    step(1'b0, 16'h0000, 0, 1'b0);
    // saturated counter: lone owner keeps grant, then yields once another requester appears
    for (int k = 0; k < 6; k++) step(1'b0, 16'h0004, 2, 1'b1);
`ifdef RR_ARB_HOLD_LIMIT_EN
    step(1'b0, 16'h0024, 5, 1'b1);
`else
    step(1'b0, 16'h0024, 2, 1'b1);
`endif
    step(1'b0, 16'h0000, 0, 1'b0);
    @(posedge clk);
    #3;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
